// File: rtl/pcie_cpl_sched_bfm.sv
// Completion scheduler for the PCIe target BFM: pops MRd headers from the RX BFM and
// answers each one with CplD TLPs whose payload DWs carry their own byte address.
module pcie_cpl_sched_bfm #(
  parameter int          HDR_WD     = 128,
  parameter int          DT_WD      = 128,
  parameter int          MAX_PLD_DW = 32,
  parameter logic [15:0] CPL_ID     = 16'h0100
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              mrd_rdempty_i,
  output logic              mrd_rden_o,
  input  logic [HDR_WD-1:0] mrd_hdr_i,
  output logic              trgtlookup_id_rden_o,
  input  logic [9:0]        trgtlookup_id_i,
  input  logic              tx_halt_i,
  output logic              tx_hv_o,
  output logic [95:0]       tx_hdr_o,
  output logic [9:0]        tx_lookup_id_o,
  output logic              tx_dv_o,
  output logic [DT_WD-1:0]  tx_data_o,
  output logic [3:0]        tx_dwen_o,
  output logic              tx_eot_o,
  output logic              busy_o,
  output logic [15:0]       cpl_cnt_o,
  output logic [7:0]        drop_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    HDR,
    DATA
  } state_e;

  localparam logic [10:0] MaxSeg = 11'(MAX_PLD_DW);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [10:0] rem_q, rem_d;
  logic [10:0] segLeft_q, segLeft_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [9:0]  lookupId_q, lookupId_d;
  logic [15:0] cplCnt_q, cplCnt_d;
  logic [7:0]  dropCnt_q, dropCnt_d;

  logic [10:0] seg;
  logic [2:0]  beatDw;
  logic [11:0] byteCnt;
  logic        isMrd;
  logic        unusedHdr;

  // Only the MRd routing fields are consumed; BEs, attributes and address low bits are not.
  assign unusedHdr = ^{mrd_hdr_i[31], mrd_hdr_i[23:10], mrd_hdr_i[39:32],
                       mrd_hdr_i[65:64], mrd_hdr_i[97:96]};

  assign seg     = (rem_q > MaxSeg) ? MaxSeg : rem_q;
  assign beatDw  = (segLeft_q > 11'd4) ? 3'd4 : segLeft_q[2:0];
  assign byteCnt = {rem_q[9:0], 2'b00};
  assign isMrd   = !mrd_hdr_i[30] && (mrd_hdr_i[28:24] == 5'd0);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      segLeft_q  <= '0;
      rid_q      <= '0;
      tag_q      <= '0;
      lookupId_q <= '0;
      cplCnt_q   <= '0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      segLeft_q  <= segLeft_d;
      rid_q      <= rid_d;
      tag_q      <= tag_d;
      lookupId_q <= lookupId_d;
      cplCnt_q   <= cplCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    rem_d                = rem_q;
    segLeft_d            = segLeft_q;
    rid_d                = rid_q;
    tag_d                = tag_q;
    lookupId_d           = lookupId_q;
    cplCnt_d             = cplCnt_q;
    dropCnt_d            = dropCnt_q;
    mrd_rden_o           = 1'b0;
    trgtlookup_id_rden_o = 1'b0;
    tx_hv_o              = 1'b0;
    tx_dv_o              = 1'b0;
    tx_eot_o             = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mrd_rdempty_i) state_d = POP;
      end
      POP: begin
        mrd_rden_o           = 1'b1;
        trgtlookup_id_rden_o = 1'b1;
        state_d              = LOAD;
      end
      LOAD: begin
        lookupId_d = trgtlookup_id_i;
        if (isMrd) begin
          rem_d   = (mrd_hdr_i[9:0] == 10'd0) ? 11'd1024 : {1'b0, mrd_hdr_i[9:0]};
          addr_d  = (mrd_hdr_i[29] ? mrd_hdr_i[127:96] : mrd_hdr_i[95:64]) & 32'hFFFF_FFFC;
          rid_d   = mrd_hdr_i[63:48];
          tag_d   = mrd_hdr_i[47:40];
          state_d = HDR;
        end else begin
          if (dropCnt_q != 8'hFF) dropCnt_d = dropCnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      HDR: begin
        tx_hv_o = 1'b1;
        if (!tx_halt_i) begin
          segLeft_d = seg;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_dv_o  = 1'b1;
        tx_eot_o = (segLeft_q <= 11'd4);
        if (!tx_halt_i) begin
          addr_d    = addr_q + {27'd0, beatDw, 2'b00};
          segLeft_d = segLeft_q - {8'd0, beatDw};
          // seg is still derived from the pre-decrement remainder on the eot beat
          if (tx_eot_o) begin
            rem_d    = rem_q - seg;
            cplCnt_d = cplCnt_q + 16'd1;
            state_d  = (rem_q == seg) ? IDLE : HDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_hdr_o  = '0;
    tx_data_o = '0;
    tx_dwen_o = 4'b0000;
    if (tx_hv_o) begin
      tx_hdr_o[31:0]  = {1'b0, 3'b010, 5'b01010, 13'd0, seg[9:0]};
      tx_hdr_o[63:32] = {CPL_ID, 3'b000, 1'b0, byteCnt};
      tx_hdr_o[95:64] = {rid_q, tag_q, 1'b0, addr_q[6:0]};
    end
    if (tx_dv_o) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < beatDw) begin
          tx_data_o[32*k +: 32] = addr_q + 32'(4 * k);
          tx_dwen_o[k]          = 1'b1;
        end
      end
    end
  end

  assign tx_lookup_id_o = lookupId_q;
  assign busy_o         = (state_q != IDLE);
  assign cpl_cnt_o      = cplCnt_q;
  assign drop_cnt_o     = dropCnt_q;

endmodule

// File: tb/tb_pcie_cpl_sched_bfm.sv
// Directed bench for pcie_cpl_sched_bfm: a queue models the RX BFM FIFO/lookup RAM and a
// negedge monitor logs every accepted completion header and data beat.
module tb_pcie_cpl_sched_bfm;

  logic         core_clk;
  logic         core_rst_n;
  logic         mrd_rdempty_i;
  logic         mrd_rden_o;
  logic [127:0] mrd_hdr_i;
  logic         trgtlookup_id_rden_o;
  logic [9:0]   trgtlookup_id_i;
  logic         tx_halt_i;
  logic         tx_hv_o;
  logic [95:0]  tx_hdr_o;
  logic [9:0]   tx_lookup_id_o;
  logic         tx_dv_o;
  logic [127:0] tx_data_o;
  logic [3:0]   tx_dwen_o;
  logic         tx_eot_o;
  logic         busy_o;
  logic [15:0]  cpl_cnt_o;
  logic [7:0]   drop_cnt_o;

  pcie_cpl_sched_bfm dut (
    .core_clk            (core_clk),
    .core_rst_n          (core_rst_n),
    .mrd_rdempty_i       (mrd_rdempty_i),
    .mrd_rden_o          (mrd_rden_o),
    .mrd_hdr_i           (mrd_hdr_i),
    .trgtlookup_id_rden_o(trgtlookup_id_rden_o),
    .trgtlookup_id_i     (trgtlookup_id_i),
    .tx_halt_i           (tx_halt_i),
    .tx_hv_o             (tx_hv_o),
    .tx_hdr_o            (tx_hdr_o),
    .tx_lookup_id_o      (tx_lookup_id_o),
    .tx_dv_o             (tx_dv_o),
    .tx_data_o           (tx_data_o),
    .tx_dwen_o           (tx_dwen_o),
    .tx_eot_o            (tx_eot_o),
    .busy_o              (busy_o),
    .cpl_cnt_o           (cpl_cnt_o),
    .drop_cnt_o          (drop_cnt_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [127:0] hdrQ[$];
  logic [9:0]   idQ[$];
  logic [95:0]  hdrLog[$];
  logic [127:0] dataLog[$];
  logic [3:0]   dwenLog[$];
  logic         eotLog[$];
  int           rdenCount = 0;
  int           overlapCount = 0;
  int           holdSeen = 0;
  int           holdErr = 0;
  logic         prevHaltHv = 1'b0;
  logic         prevHaltDv = 1'b0;
  logic [95:0]  prevHdr;
  logic [127:0] prevData;
  logic [3:0]   prevDwen;
  logic         prevEot;
  logic [31:0]  haltPat = 32'hB65D_9A3C;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    else
      passCount++;
  endtask

  // RX BFM model: pop happens mid-cycle so the header is valid in the DUT's LOAD cycle.
  always @(negedge core_clk) begin
    if (mrd_rden_o) begin
      rdenCount++;
      if (hdrQ.size() > 0) begin
        mrd_hdr_i       = hdrQ.pop_front();
        trgtlookup_id_i = idQ.pop_front();
      end
      mrd_rdempty_i = (hdrQ.size() == 0);
    end
  end

  always @(negedge core_clk) begin
    if (!core_rst_n) begin
      prevHaltHv = 1'b0;
      prevHaltDv = 1'b0;
    end else begin
      if (tx_hv_o && tx_dv_o) overlapCount++;
      if (prevHaltHv) begin
        holdSeen++;
        if (!tx_hv_o || tx_hdr_o !== prevHdr) holdErr++;
      end
      if (prevHaltDv) begin
        holdSeen++;
        if (!tx_dv_o || tx_data_o !== prevData || tx_dwen_o !== prevDwen || tx_eot_o !== prevEot)
          holdErr++;
      end
      prevHaltHv = tx_hv_o && tx_halt_i;
      prevHaltDv = tx_dv_o && tx_halt_i;
      prevHdr    = tx_hdr_o;
      prevData   = tx_data_o;
      prevDwen   = tx_dwen_o;
      prevEot    = tx_eot_o;
      if (tx_hv_o && !tx_halt_i) hdrLog.push_back(tx_hdr_o);
      if (tx_dv_o && !tx_halt_i) begin
        dataLog.push_back(tx_data_o);
        dwenLog.push_back(tx_dwen_o);
        eotLog.push_back(tx_eot_o);
      end
    end
  end

  function automatic logic [127:0] mkHdr(input logic [1:0] fmt, input logic [9:0] len,
                                         input logic [31:0] addr, input logic [15:0] rid,
                                         input logic [7:0] tag);
    return {32'h0, addr, rid, tag, 8'h0F, 1'b0, fmt, 5'b00000, 14'd0, len};
  endfunction

  task automatic clearLogs();
    hdrLog.delete();
    dataLog.delete();
    dwenLog.delete();
    eotLog.delete();
  endtask

  task automatic pushHdr(input logic [127:0] hdr, input logic [9:0] id);
    hdrQ.push_back(hdr);
    idQ.push_back(id);
    mrd_rdempty_i = 1'b0;
  endtask

  // Sampled at posedge+1 so nothing races the DUT edge or the negedge FIFO pop.
  task automatic waitIdle(input bit useHalt);
    int cyc;
    cyc = 0;
    forever begin
      @(posedge core_clk);
      #1;
      cyc++;
      tx_halt_i = useHalt ? haltPat[cyc % 32] : 1'b0;
      if (cyc >= 3 && !busy_o && hdrQ.size() == 0) break;
      if (cyc > 2000) begin
        checkOutput("idle timeout", 1'b1, 1'b0);
        break;
      end
    end
    tx_halt_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [127:0] hdr, input logic [9:0] id, input bit useHalt);
    clearLogs();
    @(posedge core_clk);
    #2;
    pushHdr(hdr, id);
    waitIdle(useHalt);
  endtask

  initial begin
    int rdenBefore;
    int cyc;
    logic [31:0] expDw;
    core_rst_n      = 1'b0;
    mrd_rdempty_i   = 1'b1;
    mrd_hdr_i       = '0;
    trgtlookup_id_i = '0;
    tx_halt_i       = 1'b0;
    repeat (3) @(negedge core_clk);
    checkOutput("reset hv", tx_hv_o, 1'b0);
    checkOutput("reset dv", tx_dv_o, 1'b0);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset rden", mrd_rden_o, 1'b0);
    checkOutput("reset cpl_cnt", cpl_cnt_o, 16'd0);
    checkOutput("reset drop_cnt", drop_cnt_o, 8'd0);
    core_rst_n = 1'b1;

    $display("[TB] single DW read");
    rdenBefore = rdenCount;
    applyStimulus(mkHdr(2'b00, 10'd1, 32'h1C00_0010, 16'h0000, 8'h05), 10'h2A, 1'b0);
    checkOutput("t1 pops", rdenCount - rdenBefore, 1);
    checkOutput("t1 hdr count", hdrLog.size(), 1);
    checkOutput("t1 hdr", hdrLog[0], {32'h0000_0510, 32'h0100_0004, 32'h2500_0001});
    checkOutput("t1 beat count", dataLog.size(), 1);
    checkOutput("t1 data", dataLog[0], 128'h1C00_0010);
    checkOutput("t1 dwen", dwenLog[0], 4'b0001);
    checkOutput("t1 eot", eotLog[0], 1'b1);
    checkOutput("t1 lookup id", tx_lookup_id_o, 10'h2A);
    checkOutput("t1 cpl_cnt", cpl_cnt_o, 16'd1);

    $display("[TB] 40 DW read split in two");
    applyStimulus(mkHdr(2'b00, 10'd40, 32'h1C00_0000, 16'h1234, 8'h06), 10'h003, 1'b0);
    checkOutput("t2 hdr count", hdrLog.size(), 2);
    checkOutput("t2 beat count", dataLog.size(), 10);
    checkOutput("t2 hdr0", hdrLog[0], {32'h1234_0600, 32'h0100_00A0, 32'h2500_0020});
    checkOutput("t2 beat0", dataLog[0], {32'h1C00_000C, 32'h1C00_0008, 32'h1C00_0004, 32'h1C00_0000});
    checkOutput("t2 beat6 eot", eotLog[6], 1'b0);
    checkOutput("t2 beat7 eot", eotLog[7], 1'b1);
    checkOutput("t2 beat7 dwen", dwenLog[7], 4'b1111);
    checkOutput("t2 hdr1", hdrLog[1], {32'h1234_0600, 32'h0100_0020, 32'h2500_0008});
    checkOutput("t2 beat8 dw0", dataLog[8][31:0], 32'h1C00_0080);
    checkOutput("t2 beat9 eot", eotLog[9], 1'b1);
    checkOutput("t2 cpl_cnt", cpl_cnt_o, 16'd3);

    $display("[TB] 1024 DW read");
    applyStimulus(mkHdr(2'b00, 10'd0, 32'h2000_0000, 16'h00AB, 8'h11), 10'h100, 1'b0);
    checkOutput("t3 hdr count", hdrLog.size(), 32);
    checkOutput("t3 beat count", dataLog.size(), 256);
    checkOutput("t3 first dw0", hdrLog[0][31:0], 32'h2500_0020);
    checkOutput("t3 first bytecnt", hdrLog[0][63:32], 32'h0100_0000);
    checkOutput("t3 last bytecnt", hdrLog[31][63:32], 32'h0100_0080);
    checkOutput("t3 last dw2", hdrLog[31][95:64], 32'h00AB_1100);
    checkOutput("t3 last addr", dataLog[248][31:0], 32'h2000_0F80);
    checkOutput("t3 cpl_cnt", cpl_cnt_o, 16'd35);

    $display("[TB] 13 DW read under halt");
    applyStimulus(mkHdr(2'b00, 10'd13, 32'h3000_0040, 16'h0001, 8'h22), 10'h055, 1'b1);
    checkOutput("t4 hdr count", hdrLog.size(), 1);
    checkOutput("t4 hdr", hdrLog[0], {32'h0001_2240, 32'h0100_0034, 32'h2500_000D});
    checkOutput("t4 beat count", dataLog.size(), 4);
    for (int b = 0; b < 4 && b < dataLog.size(); b++) begin
      checkOutput("t4 dwen", dwenLog[b], (b == 3) ? 4'b0001 : 4'b1111);
      checkOutput("t4 eot", eotLog[b], (b == 3) ? 1'b1 : 1'b0);
      for (int k = 0; k < 4; k++) begin
        expDw = (b * 4 + k < 13) ? 32'h3000_0040 + 32'(16 * b + 4 * k) : 32'h0;
        checkOutput("t4 data", dataLog[b][32*k +: 32], expDw);
      end
    end
    checkOutput("t4 halt exercised", holdSeen > 0, 1'b1);
    checkOutput("t4 halt hold", holdErr, 0);
    checkOutput("t4 cpl_cnt", cpl_cnt_o, 16'd36);

    $display("[TB] non-MRd header dropped");
    clearLogs();
    @(posedge core_clk);
    #2;
    pushHdr(mkHdr(2'b10, 10'd4, 32'h4000_0000, 16'h0002, 8'h33), 10'h077);
    pushHdr(mkHdr(2'b00, 10'd1, 32'h1C00_0100, 16'h0003, 8'h07), 10'h005);
    waitIdle(1'b0);
    checkOutput("t5 drop_cnt", drop_cnt_o, 8'd1);
    checkOutput("t5 hdr count", hdrLog.size(), 1);
    checkOutput("t5 hdr", hdrLog[0], {32'h0003_0700, 32'h0100_0004, 32'h2500_0001});
    checkOutput("t5 lookup id", tx_lookup_id_o, 10'h005);
    checkOutput("t5 cpl_cnt", cpl_cnt_o, 16'd37);

    $display("[TB] reset during data");
    clearLogs();
    @(posedge core_clk);
    #2;
    pushHdr(mkHdr(2'b00, 10'd40, 32'h1C00_0000, 16'h1234, 8'h08), 10'h009);
    cyc = 0;
    while (!tx_dv_o && cyc < 50) begin
      @(negedge core_clk);
      cyc++;
    end
    checkOutput("t6 reached data", tx_dv_o, 1'b1);
    rdenBefore = rdenCount;
    #1;
    core_rst_n = 1'b0;
    #1;
    checkOutput("t6 dv", tx_dv_o, 1'b0);
    checkOutput("t6 hv", tx_hv_o, 1'b0);
    checkOutput("t6 busy", busy_o, 1'b0);
    checkOutput("t6 dwen", tx_dwen_o, 4'b0000);
    checkOutput("t6 lookup id", tx_lookup_id_o, 10'h000);
    checkOutput("t6 cpl_cnt", cpl_cnt_o, 16'd0);
    checkOutput("t6 drop_cnt", drop_cnt_o, 8'd0);
    repeat (3) @(negedge core_clk);
    core_rst_n = 1'b1;
    repeat (5) @(negedge core_clk);
    checkOutput("t6 no extra pop", rdenCount - rdenBefore, 0);
    checkOutput("t6 idle", busy_o, 1'b0);
    applyStimulus(mkHdr(2'b00, 10'd1, 32'h1C00_0200, 16'h0004, 8'h09), 10'h1FF, 1'b0);
    checkOutput("t6 fresh hdr count", hdrLog.size(), 1);
    checkOutput("t6 fresh data", dataLog[0], 128'h1C00_0200);
    checkOutput("t6 fresh cpl_cnt", cpl_cnt_o, 16'd1);
    checkOutput("t6 fresh lookup id", tx_lookup_id_o, 10'h1FF);

    checkOutput("hv/dv overlap", overlapCount, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
